uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 214 +++++++++++++++++++++
 tb/tb_uart_tx_arb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Two-requester word arbiter feeding a byte-serial character sink through a DEPTH-entry FIFO.
// Latency: a word accepted in cycle N into an empty queue with the serialiser idle gives its first tx_wen in N+2.
// Backpressure: req_ready drops for both requesters while the FIFO is full; tx_ready low freezes the current byte.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-low reset
//   req_valid[1:0]            per-requester word write request (bit i = requester i)
//   req_byte_en[7:0]          byte lanes per requester, [4i+3:4i] = requester i
//   req_data[63:0]            write data per requester, [32i+31:32i] = requester i
//   req_ready[1:0]            requester i's word is taken this cycle when valid
//   tx_wen/tx_byte_en/tx_data one byte per cycle towards the sink, byte kept in its own lane
//   tx_ready                  sink takes the presented byte when high
//   busy                      a word is queued or being emitted
module uart_tx_arb #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [7:0]  req_byte_en,
    input  logic [63:0] req_data,
    output logic [1:0]  req_ready,
    output logic        tx_wen,
    output logic [3:0]  tx_byte_en,
    output logic [31:0] tx_data,
    input  logic        tx_ready,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t         r_state;
    logic [3:0]     r_mask;        // lanes of the current word still to emit
    logic [31:0]    r_data;
    logic [35:0]    r_mem [DEPTH]; // {byte_en, data}
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic           r_last;        // requester accepted most recently

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic           w_grant;
    logic           w_full;
    logic           w_empty;
    logic           w_accept;
    logic           w_push;
    logic           w_pop;
    logic [3:0]     w_sel_be;
    logic [31:0]    w_sel_data;
    logic [35:0]    w_head;
    logic [3:0]     w_lane;
    logic [3:0]     w_mask_rem;
    logic [31:0]    w_lane_bits;
    state_t         w_state_nxt;
    logic [3:0]     w_mask_nxt;
    logic [31:0]    w_data_nxt;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rptr];

    // ------------------------------------------------------------------
    // Round-robin arbitration. A lone requester always wins; on a tie the
    // requester that was not accepted last wins. With nobody requesting the
    // grant simply points at the tie winner, which is harmless because
    // nothing is accepted.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant = ~r_last;
        if (req_valid == 2'b01) begin
            w_grant = 1'b0;
        end else if (req_valid == 2'b10) begin
            w_grant = 1'b1;
        end
    end

    // Fullness is judged on the registered count only, so a pop in the same
    // cycle never opens the door early. The reset term keeps both ready bits
    // low while rst is held, even though the cleared count reads as empty.
    always_comb begin
        req_ready = 2'b00;
        if (rst && !w_full) begin
            req_ready = w_grant ? 2'b10 : 2'b01;
        end
    end

    assign w_accept   = |(req_valid & req_ready);
    assign w_sel_be   = w_grant ? req_byte_en[7:4] : req_byte_en[3:0];
    assign w_sel_data = w_grant ? req_data[63:32]  : req_data[31:0];

    // A word with no lanes enabled is consumed (and moves the grant pointer)
    // but never occupies a FIFO slot.
    assign w_push = w_accept && (w_sel_be != 4'b0000);

    // ------------------------------------------------------------------
    // Serialiser: lowest remaining lane first.
    // ------------------------------------------------------------------
    assign w_lane      = r_mask & (~r_mask + 4'd1);
    assign w_mask_rem  = r_mask & ~w_lane;
    assign w_lane_bits = {{8{w_lane[3]}}, {8{w_lane[2]}}, {8{w_lane[1]}}, {8{w_lane[0]}}};

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_data_nxt  = r_data;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_mask_nxt  = w_head[35:32];
                    w_data_nxt  = w_head[31:0];
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (tx_ready) begin
                    w_mask_nxt = w_mask_rem;
                    if (w_mask_rem == 4'b0000) begin
                        // Chain straight into the next word so back-to-back
                        // words leave no idle cycle on the sink.
                        if (!w_empty) begin
                            w_pop      = 1'b1;
                            w_mask_nxt = w_head[35:32];
                            w_data_nxt = w_head[31:0];
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        tx_wen     = 1'b0;
        tx_byte_en = 4'b0000;
        tx_data    = 32'h0;
        if (r_state == EMIT) begin
            tx_wen     = 1'b1;
            tx_byte_en = w_lane;
            tx_data    = r_data & w_lane_bits;
        end
    end

    assign busy = (r_state != IDLE) || !w_empty;

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    // Storage needs no reset: the cleared count marks every entry invalid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_sel_be, w_sel_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // r_last starts at 1 so that requester 0 takes the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_grant;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_mask  <= 4'b0000;
            r_data  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_data  <= w_data_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [7:0]  req_byte_en;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        tx_wen;
    logic [3:0]  tx_byte_en;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        busy;

    int n_total;
    int n_bad;

    uart_tx_arb #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_byte_en (req_byte_en),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_wen      (tx_wen),
        .tx_byte_en  (tx_byte_en),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_tx(input string tag, input logic wen, input logic [3:0] be, input logic [31:0] dat);
        chk({tag, ".wen"}, {63'h0, tx_wen}, {63'h0, wen});
        chk({tag, ".be"},  {60'h0, tx_byte_en}, {60'h0, be});
        chk({tag, ".dat"}, {32'h0, tx_data}, {32'h0, dat});
    endtask

    task automatic set_req(input logic [1:0] v, input logic [3:0] be0, input logic [31:0] d0,
                           input logic [3:0] be1, input logic [31:0] d1);
        req_valid   = v;
        req_byte_en = {be1, be0};
        req_data    = {d1, d0};
    endtask

    // Hold reset for two edges with a request offered, checking the reset
    // outputs; release just after a rising edge.
    task automatic do_reset();
        rst = 1'b0;
        set_req(2'b01, 4'hF, 32'h1234_5678, 4'hF, 32'h9ABC_DEF0);
        @(negedge clk);
        chk("rst.ready", {62'h0, req_ready}, 64'h0);
        chk_tx("rst", 1'b0, 4'h0, 32'h0);
        chk("rst.busy", {63'h0, busy}, 64'h0);
        set_req(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b0;
        tx_ready  = 1'b0;
        set_req(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);

        // ---- single full word, sink always ready ----
        tx_ready = 1'b1;
        do_reset();
        set_req(2'b01, 4'hF, 32'h4443_4241, 4'h0, 32'h0);
        @(negedge clk);
        chk("t1.ready", {62'h0, req_ready}, 64'h1);
        chk("t1.busy0", {63'h0, busy}, 64'h0);
        step();
        set_req(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk_tx("t1.n1", 1'b0, 4'h0, 32'h0);
        chk("t1.busy1", {63'h0, busy}, 64'h1);
        step();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_tx("t1.emit", 1'b1, 4'(1 << k), (32'h41 + 32'(k)) << (8 * k));
            step();
        end
        @(negedge clk);
        chk_tx("t1.end", 1'b0, 4'h0, 32'h0);
        chk("t1.busy6", {63'h0, busy}, 64'h0);

        // ---- both requesters every cycle: alternating grants ----
        tx_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            if (k < 4) set_req(2'b11, 4'h1, 32'h30, 4'h1, 32'h31);
            else       set_req(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);
            @(negedge clk);
            if (k < 4) chk("t2.ready", {62'h0, req_ready}, (k % 2 == 0) ? 64'h1 : 64'h2);
            if (k >= 2 && k <= 5) chk_tx("t2.emit", 1'b1, 4'h1, 32'h30 + 32'(k & 1));
            else                  chk_tx("t2.quiet", 1'b0, 4'h0, 32'h0);
            step();
        end

        // ---- sink stalled: one word in the serialiser, FIFO fills at 4 ----
        tx_ready = 1'b0;
        do_reset();
        set_req(2'b01, 4'h1, 32'h50, 4'h0, 32'h0);
        @(negedge clk);
        chk("t3.ready0", {62'h0, req_ready}, 64'h1);
        step();
        set_req(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);
        step();
        for (int j = 0; j < 5; j++) begin
            set_req(2'b01, 4'h1, 32'h51 + 32'(j), 4'h0, 32'h0);
            @(negedge clk);
            chk("t3.fill", {62'h0, req_ready}, (j < 4) ? 64'h1 : 64'h0);
            chk_tx("t3.hold", 1'b1, 4'h1, 32'h50);
            step();
        end
        // Full and popping this cycle: ready must still be low.
        tx_ready = 1'b1;
        @(negedge clk);
        chk("t3.fullpop", {62'h0, req_ready}, 64'h0);
        chk_tx("t3.d0", 1'b1, 4'h1, 32'h50);
        step();
        set_req(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);
        for (int j = 1; j < 5; j++) begin
            @(negedge clk);
            chk_tx("t3.drain", 1'b1, 4'h1, 32'h50 + 32'(j));
            step();
        end
        @(negedge clk);
        chk_tx("t3.end", 1'b0, 4'h0, 32'h0);
        chk("t3.busy", {63'h0, busy}, 64'h0);

        // ---- sparse lanes with toggling tx_ready ----
        tx_ready = 1'b0;
        do_reset();
        set_req(2'b01, 4'b1010, 32'hAABB_CCDD, 4'h0, 32'h0);
        step();
        set_req(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk_tx("t4.n1", 1'b0, 4'h0, 32'h0);
        step();
        @(negedge clk);
        chk_tx("t4.l1a", 1'b1, 4'h2, 32'h0000_CC00);
        step();
        tx_ready = 1'b1;
        @(negedge clk);
        chk_tx("t4.l1b", 1'b1, 4'h2, 32'h0000_CC00);
        step();
        tx_ready = 1'b0;
        @(negedge clk);
        chk_tx("t4.l3a", 1'b1, 4'h8, 32'hAA00_0000);
        step();
        tx_ready = 1'b1;
        @(negedge clk);
        chk_tx("t4.l3b", 1'b1, 4'h8, 32'hAA00_0000);
        step();
        tx_ready = 1'b0;
        @(negedge clk);
        chk_tx("t4.end", 1'b0, 4'h0, 32'h0);
        chk("t4.busy", {63'h0, busy}, 64'h0);

        // ---- empty byte_en: consumed, nothing emitted, grant still moves ----
        tx_ready = 1'b1;
        do_reset();
        set_req(2'b01, 4'h0, 32'hDEAD_BEEF, 4'h0, 32'h0);
        @(negedge clk);
        chk("t5.ready", {62'h0, req_ready}, 64'h1);
        step();
        set_req(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk_tx("t5.quiet", 1'b0, 4'h0, 32'h0);
            chk("t5.busy", {63'h0, busy}, 64'h0);
            step();
        end
        set_req(2'b11, 4'h1, 32'h70, 4'h1, 32'h71);
        @(negedge clk);
        chk("t5.grant", {62'h0, req_ready}, 64'h2);
        step();
        set_req(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);

        // ---- reset in the middle of emitting with 3 words queued ----
        tx_ready = 1'b0;
        do_reset();
        for (int j = 0; j < 4; j++) begin
            set_req(2'b01, 4'h1, 32'h61 + 32'(j), 4'h0, 32'h0);
            step();
        end
        set_req(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk_tx("t6.pre", 1'b1, 4'h1, 32'h61);
        chk("t6.busypre", {63'h0, busy}, 64'h1);
        #2;
        set_req(2'b01, 4'h1, 32'h99, 4'h0, 32'h0);
        rst = 1'b0;
        #1;
        chk_tx("t6.rst", 1'b0, 4'h0, 32'h0);
        chk("t6.rstbusy", {63'h0, busy}, 64'h0);
        chk("t6.rstready", {62'h0, req_ready}, 64'h0);
        set_req(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tx_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t6.nostale", {63'h0, tx_wen}, 64'h0);
            chk("t6.idle", {63'h0, busy}, 64'h0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
